// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the cobra bus: arbiter states, default widths
// and the Z80 strobe decode used to recognise a real memory cycle.
package cobra_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ISSUE,
    CPU_DONE,
    VID_ISSUE,
    VID_DONE
  } arb_state_t;

  // Refresh cycles also pull mreq_n low, so rfsh_n must be high for a real access
  function automatic logic is_mem_access(input logic mreq_n, input logic rfsh_n,
                                         input logic rd_n, input logic wr_n);
    return !mreq_n && rfsh_n && (!rd_n || !wr_n);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Port bundle between the arbiter and the single-ported memory.
// The arbiter drives address, write data and strobes; memory returns read data.
interface mem_arbiter_if #(
  parameter int ADDR_W = cobra_bus_pkg::ADDR_W,
  parameter int DATA_W = cobra_bus_pkg::DATA_W
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rd;
  logic              wr;

  modport master (
    output addr,
    output din,
    output rd,
    output wr,
    input  dout
  );

  modport slave (
    input  addr,
    input  din,
    input  rd,
    input  wr,
    output dout
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory between the Z80 bus and the video fetcher, one access every
// two cycles; video wins ties until it has starved a waiting CPU VID_BURST times.
module mem_arbiter #(
  parameter int ADDR_W    = cobra_bus_pkg::ADDR_W,
  parameter int DATA_W    = cobra_bus_pkg::DATA_W,
  parameter int VID_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_mreq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic              cpu_rfsh_n,
  output logic              cpu_wait_n,
  output logic [DATA_W-1:0] cpu_di,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  mem_arbiter_if.master     mem
);

  import cobra_bus_pkg::*;

  localparam logic [3:0] BURST_LIM = 4'(VID_BURST);

  arb_state_t state;
  logic       served;
  logic       cpu_is_wr;
  logic [3:0] streak;
  logic       cpu_req;
  logic       cpu_pending;
  logic       arb_point;
  logic       vid_win;
  logic       cpu_win;

  assign cpu_req    = is_mem_access(cpu_mreq_n, cpu_rfsh_n, cpu_rd_n, cpu_wr_n) && !served;
  assign cpu_wait_n = !reset_n || !cpu_req;

  // The request being completed in CPU_DONE must not win the arbitration again
  assign cpu_pending = cpu_req && (state != CPU_DONE);
  assign arb_point   = (state == IDLE) || (state == CPU_DONE) || (state == VID_DONE);
  assign vid_win     = vid_req && !(cpu_pending && (streak == BURST_LIM));
  assign cpu_win     = cpu_pending && !vid_win;

  // Single FSM: strobes, acks and capture registers are all decoded into flops here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      streak    <= '0;
      served    <= 1'b0;
      cpu_is_wr <= 1'b0;
      cpu_di    <= '0;
      vid_ack   <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      mem.addr  <= '0;
      mem.din   <= '0;
      mem.rd    <= 1'b0;
      mem.wr    <= 1'b0;
    end else begin
      mem.rd    <= 1'b0;
      mem.wr    <= 1'b0;
      vid_ack   <= 1'b0;
      vid_valid <= 1'b0;

      if (state == CPU_DONE) begin
        served <= 1'b1;
      end else if (cpu_mreq_n) begin
        served <= 1'b0;
      end

      if (!cpu_req) begin
        streak <= '0;
      end

      case (state)
        CPU_ISSUE: state <= CPU_DONE;
        VID_ISSUE: state <= VID_DONE;
        CPU_DONE: begin
          if (!cpu_is_wr) begin
            cpu_di <= mem.dout;
          end
        end
        VID_DONE: begin
          vid_data  <= mem.dout;
          vid_valid <= 1'b1;
        end
        default: ;
      endcase

      // A grant here overrides the ISSUE->DONE step and the streak clear above
      if (arb_point) begin
        if (vid_win) begin
          state    <= VID_ISSUE;
          mem.addr <= vid_addr;
          mem.rd   <= 1'b1;
          vid_ack  <= 1'b1;
          if (cpu_pending && (streak != BURST_LIM)) begin
            streak <= streak + 4'd1;
          end
        end else if (cpu_win) begin
          state     <= CPU_ISSUE;
          mem.addr  <= cpu_addr;
          cpu_is_wr <= !cpu_wr_n;
          streak    <= '0;
          if (!cpu_wr_n) begin
            mem.wr  <= 1'b1;
            mem.din <= cpu_dout;
          end else begin
            mem.rd  <= 1'b1;
          end
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus tasks queue the expected memory
// accesses, CPU completions and video data; a monitor pops and compares them.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic        cpu_rfsh_n;
  logic        cpu_wait_n;
  logic [7:0]  cpu_di;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack;
  logic        vid_valid;
  logic [7:0]  vid_data;

  mem_arbiter_if mem_if ();

  mem_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (8),
    .VID_BURST (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_rfsh_n (cpu_rfsh_n),
    .cpu_wait_n (cpu_wait_n),
    .cpu_di     (cpu_di),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_valid  (vid_valid),
    .vid_data   (vid_data),
    .mem        (mem_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory holds addr[7:0]^addr[15:8] everywhere except the most recent write
  logic        wr_any = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clk) begin
    if (mem_if.wr) begin
      wr_any  <= 1'b1;
      wr_addr <= mem_if.addr;
      wr_data <= mem_if.din;
    end
    if (mem_if.rd) begin
      mem_if.dout <= (wr_any && wr_addr == mem_if.addr) ? wr_data : init_val(mem_if.addr);
    end
  end

  typedef struct {
    logic        wr;
    logic        vid;
    logic [15:0] addr;
    logic [7:0]  din;
    int          gap;
  } acc_t;

  typedef struct {
    logic [7:0] di;
    int         waits;
  } cpu_t;

  acc_t       exp_acc[$];
  cpu_t       exp_cpu[$];
  logic [7:0] exp_vdata[$];

  int   checks = 0;
  int   failures = 0;
  int   timeouts = 0;
  logic end_req = 1'b0;
  logic end_done = 1'b0;

  task automatic push_acc(input logic wr, input logic vid, input logic [15:0] a,
                          input logic [7:0] d, input int gap);
    acc_t e;
    e.wr = wr; e.vid = vid; e.addr = a; e.din = d; e.gap = gap;
    exp_acc.push_back(e);
  endtask

  task automatic push_cpu(input logic [7:0] di, input int waits);
    cpu_t e;
    e.di = di; e.waits = waits;
    exp_cpu.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge
  initial begin
    int   cyc = 0;
    int   last_acc = 0;
    int   wait_cnt = 0;
    acc_t ea;
    cpu_t ec;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        checkOutput("reset_outputs",
                    64'({cpu_wait_n, mem_if.rd, mem_if.wr, vid_ack, vid_valid,
                         mem_if.addr, mem_if.din, vid_data, cpu_di}),
                    64'({1'b1, 44'h0}));
        wait_cnt = 0;
      end else begin
        if (!cpu_mreq_n && !cpu_rfsh_n) begin
          checkOutput("refresh_wait_n", 64'(cpu_wait_n), 64'(1));
        end
        if (mem_if.rd || mem_if.wr || vid_ack) begin
          if (exp_acc.size() == 0) begin
            checkOutput("unexpected_access",
                        64'({mem_if.rd, mem_if.wr, vid_ack, mem_if.addr}), 64'h0);
          end else begin
            ea = exp_acc.pop_front();
            checkOutput("access",
                        64'({mem_if.rd, mem_if.wr, vid_ack, mem_if.addr,
                             ea.wr ? mem_if.din : 8'h00}),
                        64'({!ea.wr, ea.wr, ea.vid, ea.addr, ea.din}));
            if (ea.gap != 0) begin
              checkOutput("access_gap", 64'(cyc - last_acc), 64'(ea.gap));
            end
          end
          last_acc = cyc;
        end
        if (vid_valid) begin
          if (exp_vdata.size() == 0) begin
            checkOutput("unexpected_vid_valid", 64'(vid_data), 64'h100);
          end else begin
            checkOutput("vid_data", 64'(vid_data), 64'(exp_vdata.pop_front()));
          end
        end
        if (!cpu_wait_n) begin
          wait_cnt++;
        end else if (wait_cnt > 0) begin
          if (exp_cpu.size() == 0) begin
            checkOutput("unexpected_cpu_done", 64'(wait_cnt), 64'h0);
          end else begin
            ec = exp_cpu.pop_front();
            checkOutput("cpu_di", 64'(cpu_di), 64'(ec.di));
            checkOutput("cpu_wait_cycles", 64'(wait_cnt), 64'(ec.waits));
          end
          wait_cnt = 0;
        end
      end
      if (end_req && !end_done) begin
        checkOutput("pending_accesses", 64'(exp_acc.size()), 64'(0));
        checkOutput("pending_cpu", 64'(exp_cpu.size()), 64'(0));
        checkOutput("pending_vid_data", 64'(exp_vdata.size()), 64'(0));
        checkOutput("wait_timeouts", 64'(timeouts), 64'(0));
        end_done = 1'b1;
      end
    end
  end

  // One Z80 bus cycle: hold strobes until wait_n releases, then hold more cycles
  task automatic applyStimulus(input logic wr, input logic [15:0] a,
                               input logic [7:0] d, input int hold);
    logic seen;
    cpu_addr   = a;
    cpu_dout   = d;
    cpu_rfsh_n = 1'b1;
    cpu_rd_n   = wr;
    cpu_wr_n   = !wr;
    cpu_mreq_n = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (cpu_wait_n) seen = 1'b1;
    end
    if (!seen) timeouts++;
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk);
      #1;
    end
    cpu_mreq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Video requester: advances the address on each ack, drops vid_req after the last
  task automatic applyVideoStimulus(input logic [15:0] base, input int count);
    int acks;
    acks     = 0;
    vid_addr = base;
    vid_req  = 1'b1;
    for (int t = 0; t < 100 && acks < count; t++) begin
      @(negedge clk);
      if (vid_ack) begin
        acks++;
        if (acks == count) vid_req = 1'b0;
        else vid_addr = vid_addr + 16'd1;
      end
    end
    if (acks < count) begin
      timeouts++;
      vid_req = 1'b0;
    end
  endtask

  initial begin
    cpu_addr   = 16'h1234;
    cpu_dout   = 8'h00;
    cpu_mreq_n = 1'b0;
    cpu_rd_n   = 1'b0;
    cpu_wr_n   = 1'b1;
    cpu_rfsh_n = 1'b1;
    vid_req    = 1'b0;
    vid_addr   = 16'h0000;
    reset_n    = 1'b1;
    #1 reset_n = 1'b0;

    // Read held through reset is served fresh afterwards: 0x12^0x34 = 0x26
    push_acc(1'b0, 1'b0, 16'h1234, 8'h00, 0);
    push_cpu(8'h26, 3);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(1'b0, 16'h1234, 8'h00, 0);

    // Write leaves cpu_di at the previous read value, then read back
    push_acc(1'b1, 1'b0, 16'h4000, 8'hA5, 0);
    push_cpu(8'h26, 3);
    applyStimulus(1'b1, 16'h4000, 8'hA5, 0);
    push_acc(1'b0, 1'b0, 16'h4000, 8'h00, 0);
    push_cpu(8'hA5, 3);
    applyStimulus(1'b0, 16'h4000, 8'h00, 0);

    // Refresh with rd_n low must still not reach memory
    cpu_addr   = 16'h0077;
    cpu_rfsh_n = 1'b0;
    cpu_rd_n   = 1'b0;
    cpu_mreq_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    cpu_mreq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_rfsh_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Video stream 0x2000..0x2003, one access every two cycles
    push_acc(1'b0, 1'b1, 16'h2000, 8'h00, 0);
    push_acc(1'b0, 1'b1, 16'h2001, 8'h00, 2);
    push_acc(1'b0, 1'b1, 16'h2002, 8'h00, 2);
    push_acc(1'b0, 1'b1, 16'h2003, 8'h00, 2);
    exp_vdata.push_back(8'h20);
    exp_vdata.push_back(8'h21);
    exp_vdata.push_back(8'h22);
    exp_vdata.push_back(8'h23);
    applyVideoStimulus(16'h2000, 4);
    repeat (4) begin
      @(posedge clk);
      #1;
    end

    // Starvation: four video grants, then the CPU, then video resumes
    push_acc(1'b0, 1'b1, 16'h3000, 8'h00, 0);
    push_acc(1'b0, 1'b1, 16'h3001, 8'h00, 2);
    push_acc(1'b0, 1'b1, 16'h3002, 8'h00, 2);
    push_acc(1'b0, 1'b1, 16'h3003, 8'h00, 2);
    push_acc(1'b0, 1'b0, 16'h5A12, 8'h00, 2);
    push_acc(1'b0, 1'b1, 16'h3004, 8'h00, 2);
    push_acc(1'b0, 1'b1, 16'h3005, 8'h00, 2);
    for (int i = 0; i < 6; i++) exp_vdata.push_back(8'h30 + 8'(i));
    push_cpu(8'h48, 11);
    fork
      applyStimulus(1'b0, 16'h5A12, 8'h00, 0);
      applyVideoStimulus(16'h3000, 6);
    join
    repeat (4) begin
      @(posedge clk);
      #1;
    end

    // One access per bus cycle even with mreq_n held, then a new bus cycle
    push_acc(1'b0, 1'b0, 16'h1234, 8'h00, 0);
    push_cpu(8'h26, 3);
    applyStimulus(1'b0, 16'h1234, 8'h00, 6);
    push_acc(1'b0, 1'b0, 16'h4000, 8'h00, 0);
    push_cpu(8'hA5, 3);
    applyStimulus(1'b0, 16'h4000, 8'h00, 0);

    repeat (3) @(posedge clk);
    end_req = 1'b1;
    for (int t = 0; t < 10 && !end_done; t++) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-ported `mem_module` between the `tv80s` CPU bus and a video fetch requester. It sits between the core, the video generator and memory. It stretches CPU memory cycles with `wait_n` while video owns the memory, and it issues one memory access every two cycles. Video wins ties, bounded by a starvation limit that guarantees the CPU a slot.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 8, data width
- `VID_BURST`, 4, max consecutive video grants while a CPU request waits; range 1..15

- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cpu_addr`  in  ADDR_W  CPU address (`A`)
- `cpu_dout`  in  DATA_W  CPU write data
- `cpu_mreq_n`, `cpu_rd_n`, `cpu_wr_n`, `cpu_rfsh_n`  in  1 each  Z80 bus strobes
- `cpu_wait_n`  out  1  low stretches the CPU cycle
- `cpu_di`  out  DATA_W  read data to CPU, registered
- `vid_req`  in  1  video read request, level
- `vid_addr`  in  ADDR_W  video read address, stable while `vid_req` is high and not yet acked
- `vid_ack`  out  1  one-cycle pulse: address consumed
- `vid_valid`  out  1  one-cycle pulse: `vid_data` valid
- `vid_data`  out  DATA_W  video read data, registered
- `mem_addr`  out  ADDR_W  to `mem_module.addr`
- `mem_din`  out  DATA_W  to `mem_module.data_in`
- `mem_rd`, `mem_wr`  out  1 each  active-high strobes to memory
- `mem_dout`  in  DATA_W  memory read data, valid the cycle after `mem_rd`

## Operation
- **CPU request** is `cpu_mreq_n=0 & cpu_rfsh_n=1 & (cpu_rd_n=0 | cpu_wr_n=0) & !served`.
  - Refresh cycles (`mreq_n=0`, `rfsh_n=0`) are never forwarded to memory.
- **`served` flag** is set at the end of CPU DONE and cleared on any cycle with `cpu_mreq_n=1`. This gives exactly one access per Z80 bus cycle.
- **`cpu_wait_n`** = !(CPU request), combinational. It is forced to 1 while `reset_n=0`.
- **FSM states:** IDLE, CPU_ISSUE, CPU_DONE, VID_ISSUE, VID_DONE.
- **Arbitration** is evaluated in IDLE, CPU_DONE and VID_DONE. The next state is an ISSUE state, or IDLE if there is no request.
  - Video wins if `vid_req` is high, unless a CPU request is pending and `streak == VID_BURST`; in that case CPU wins.
  - CPU wins if it is the only requester.
- **Grant latching:** on grant, address, direction and write data are latched.
- **CPU_ISSUE:**
  - `mem_addr` = latched address.
  - Read: `mem_rd=1`.
  - Write: `mem_wr=1` and `mem_din` = latched `cpu_dout`.
- **CPU_DONE:** a read captures `mem_dout` into `cpu_di` at the end of the cycle; `served` is set.
- **VID_ISSUE:** `mem_rd=1`, `vid_ack=1`.
- **VID_DONE:** `mem_dout` is captured into `vid_data`, and `vid_valid` pulses in the following cycle.
- **`streak` counter:**
  - +1 on each video grant while a CPU request is pending; saturates at `VID_BURST`.
  - Cleared on a CPU grant or on any cycle with no CPU request.
- **`cpu_di` hold:** `cpu_di` keeps its value until the next CPU read completes. CPU writes do not alter it.

## Timing
- **Reset values:**
  - State IDLE, `streak=0`, `served=0`.
  - `mem_addr=0`, `mem_din=0`, `mem_rd=0`, `mem_wr=0`.
  - `vid_ack=0`, `vid_valid=0`, `vid_data=0`, `cpu_di=0`, `cpu_wait_n=1`.
- **Reset mid-access:** outputs go to reset values asynchronously. Whether an interrupted write lands is unspecified. After release the FSM starts in IDLE, and any still-asserted CPU request is served fresh.
- **Strobes:** `mem_rd`/`mem_wr` are registered decodes of state, high for exactly one cycle per access and never both.
- **CPU read from IDLE**, with the request seen at cycle 0:
  - ISSUE at cycle 1, DONE at cycle 2.
  - `cpu_di` valid and `cpu_wait_n=1` at cycle 3.
- **CPU write:** same cycle count as a read; memory is written at the end of cycle 1.
- **Video read**, with `vid_req` seen at cycle 0:
  - `vid_ack` at cycle 1, `vid_valid`+`vid_data` at cycle 3.
  - Back-to-back video reads give one access per 2 cycles.
- **Simultaneous video DONE and new grant:** the `vid_valid` pulse overlaps the next ISSUE cycle. This is legal.
- **`vid_req` dropped before ack:** the access is not performed.

## Structure
- Package `cobra_bus_pkg`:
  - `arb_state_t` enum (5 states).
  - `ADDR_W`/`DATA_W` defaults.
  - Z80 strobe decode helper function `is_mem_access(mreq_n, rfsh_n, rd_n, wr_n)`.
- No sub-module: FSM, streak counter and capture registers form a single module.

## Test plan
- **Reset:** hold `reset_n=0` with `cpu_mreq_n=0`, `cpu_rd_n=0` → `cpu_wait_n=1` and all outputs 0. Release → read of `0x1234` completes with `cpu_wait_n` low for 3 cycles.
- **CPU write then read:** write `0xA5` to `0x4000`, then read `0x4000` → `mem_wr` pulses once, and `cpu_di=0xA5` at cycle 3 of the read.
- **Refresh:** cycle with `mreq_n=0`, `rfsh_n=0` → no `mem_rd`/`mem_wr`, `cpu_wait_n` stays 1.
- **Video stream:** `vid_req` held for addresses `0x2000..0x2003` → 4 acks spaced 2 cycles apart, and 4 `vid_valid` pulses carrying memory contents in order.
- **Starvation:** continuous `vid_req` plus a CPU read pending with `VID_BURST=4` → exactly 4 video grants, then a CPU grant, then video resumes.
- **Single access per bus cycle:** CPU holds `mreq_n=0` for 6 cycles after being served → only one `mem_rd`. The next bus cycle, after `mreq_n` goes high, is served again.
